// File: rtl/conv_addr_gen.sv
// Convolution loop-nest sequencer: walks oc/oy/ox/ky/kx/ic and emits one tap tuple
// per accepted cycle with input, weight and output addresses and accumulation markers.
module conv_addr_gen #(
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int IM_H   = 32,
  parameter int IM_W   = 32,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int PAD    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  input  logic                 ready,
  output logic [DW-1:0]        oc,
  output logic [DW-1:0]        oy,
  output logic [DW-1:0]        ox,
  output logic [DW-1:0]        ky,
  output logic [DW-1:0]        kx,
  output logic [DW-1:0]        ic,
  output logic signed [DW:0]   in_row,
  output logic signed [DW:0]   in_col,
  output logic                 pad,
  output logic                 acc_first,
  output logic                 acc_last,
  output logic [AW-1:0]        in_addr,
  output logic [AW-1:0]        w_addr,
  output logic [AW-1:0]        out_addr,
  output logic [1:0]           dbg_state
);

  localparam int OUT_H = (IM_H + 2*PAD - K) / STRIDE + 1;
  localparam int OUT_W = (IM_W + 2*PAD - K) / STRIDE + 1;

  localparam logic [DW-1:0] IC_MAX = DW'(IN_CH - 1);
  localparam logic [DW-1:0] K_MAX  = DW'(K - 1);
  localparam logic [DW-1:0] OW_MAX = DW'(OUT_W - 1);
  localparam logic [DW-1:0] OH_MAX = DW'(OUT_H - 1);
  localparam logic [DW-1:0] OC_MAX = DW'(OUT_CH - 1);
  localparam logic [DW-1:0] ONE    = DW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  state_t state;
  assign dbg_state = state;

  // Handshake: a tuple transfers on any rising edge where valid && ready; while
  // valid && !ready every output holds, and valid stays high for the whole pass.
  logic [DW-1:0]      n_oc, n_oy, n_ox, n_ky, n_kx, n_ic;
  logic               w_ic, w_kx, w_ky, w_ox, w_oy, last, load;
  int                 r, c;
  logic signed [DW:0] n_in_row, n_in_col;
  logic               n_pad, n_af, n_al;
  logic [AW-1:0]      n_in_addr, n_w_addr, n_out_addr;

  always_comb begin
    w_ic = (ic == IC_MAX);
    w_kx = w_ic && (kx == K_MAX);
    w_ky = w_kx && (ky == K_MAX);
    w_ox = w_ky && (ox == OW_MAX);
    w_oy = w_ox && (oy == OH_MAX);
    last = w_oy && (oc == OC_MAX);
    load = ((state == IDLE) && start) || ((state == RUN) && ready && !last);
    if (state == IDLE) begin
      n_ic = '0; n_kx = '0; n_ky = '0; n_ox = '0; n_oy = '0; n_oc = '0;
    end else begin
      n_ic = w_ic ? '0 : ic + ONE;
      n_kx = w_ic ? (w_kx ? '0 : kx + ONE) : kx;
      n_ky = w_kx ? (w_ky ? '0 : ky + ONE) : ky;
      n_ox = w_ky ? (w_ox ? '0 : ox + ONE) : ox;
      n_oy = w_ox ? (w_oy ? '0 : oy + ONE) : oy;
      n_oc = w_oy ? (last ? '0 : oc + ONE) : oc;
    end
    // Full-width signed row/col so the bounds check sees true negatives.
    r = int'(n_oy) * STRIDE + int'(n_ky) - PAD;
    c = int'(n_ox) * STRIDE + int'(n_kx) - PAD;
    n_in_row   = (DW+1)'(r);
    n_in_col   = (DW+1)'(c);
    n_pad      = (r < 0) || (r >= IM_H) || (c < 0) || (c >= IM_W);
    n_af       = (n_ky == '0) && (n_kx == '0) && (n_ic == '0);
    n_al       = (n_ky == K_MAX) && (n_kx == K_MAX) && (n_ic == IC_MAX);
    n_in_addr  = n_pad ? '0 : AW'((r * IM_W + c) * IN_CH + int'(n_ic));
    n_w_addr   = AW'(((int'(n_oc) * K + int'(n_ky)) * K + int'(n_kx)) * IN_CH + int'(n_ic));
    n_out_addr = AW'((int'(n_oy) * OUT_W + int'(n_ox)) * OUT_CH + int'(n_oc));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          valid <= 1'b1;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: if (ready && last) begin
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      oc <= '0; oy <= '0; ox <= '0; ky <= '0; kx <= '0; ic <= '0;
      in_row <= '0; in_col <= '0; pad <= 1'b0;
      acc_first <= 1'b0; acc_last <= 1'b0;
      in_addr <= '0; w_addr <= '0; out_addr <= '0;
    end else if (load) begin
      oc <= n_oc; oy <= n_oy; ox <= n_ox; ky <= n_ky; kx <= n_kx; ic <= n_ic;
      in_row <= n_in_row; in_col <= n_in_col; pad <= n_pad;
      acc_first <= n_af; acc_last <= n_al;
      in_addr <= n_in_addr; w_addr <= n_w_addr; out_addr <= n_out_addr;
    end
  end

endmodule

// File: doc/conv_addr_gen.md
# conv_addr_gen

Parametrised convolution loop-nest sequencer: the next generation of the convolution control block. It walks output channel, output row, output column, kernel row, kernel column and input channel. Each cycle it emits one tap tuple with computed input, weight and output addresses, a padding flag and accumulation boundary markers. It sits between the layer controller (start/done handshake) and the MAC datapath/memories (valid/ready tap stream). Unlike its predecessor, it supports input channels, rectangular images, any stride and padding, backpressure, and flat address generation.

## Interface
- DW, 8: width of every loop counter.
- AW, 16: width of the address outputs.
- IM_H, 32: input image height.
- IM_W, 32: input image width.
- IN_CH, 1: input channels.
- OUT_CH, 32: output channels.
- K, 5: square kernel dimension.
- STRIDE, 1: stride, ≥1.
- PAD, 2: zero padding on every edge.
- Derived localparams: OUT_H = (IM_H+2*PAD-K)/STRIDE+1 and OUT_W = (IM_W+2*PAD-K)/STRIDE+1, using integer division.

- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: begin one layer pass; sampled only in IDLE.
- busy, out, 1: high while in RUN.
- done, out, 1: one-cycle pulse after the last tuple is accepted.
- valid, out, 1: a tap tuple is presented.
- ready, in, 1: the consumer accepts the tuple in this cycle.
- oc, oy, ox, ky, kx, ic, out, DW each: current loop indices.
- in_row, in_col, out, DW+1 signed: oy*STRIDE+ky-PAD and ox*STRIDE+kx-PAD.
- pad, out, 1: the tap lies outside the image.
- acc_first, out, 1: first tap of an output pixel (ky=kx=ic=0).
- acc_last, out, 1: last tap of an output pixel (ky=kx=K-1, ic=IN_CH-1).
- in_addr, out, AW: (in_row*IM_W+in_col)*IN_CH+ic; forced to 0 when pad=1.
- w_addr, out, AW: ((oc*K+ky)*K+kx)*IN_CH+ic.
- out_addr, out, AW: (oy*OUT_W+ox)*OUT_CH+oc.

## Operation
- FSM states are IDLE, RUN and FIN.
  - IDLE: waits for start=1. It then clears all indices and moves to RUN.
  - RUN: valid=1 on every cycle. On valid&ready the indices advance.
  - FIN: lasts one cycle with done=1, then returns to IDLE.
- Loop order, innermost first: ic, kx, ky, ox, oy, oc. Each index wraps to 0 when it reaches its bound and carries into the next index.
- When the tuple with every index at its maximum is accepted, the FSM moves to FIN.
- Padding taps are always emitted, never skipped, with pad=1. Every output pixel therefore receives exactly K*K*IN_CH taps.
- All outputs are registered. in_row, in_col, pad and all addresses are consistent with the indices presented in the same cycle.
- Arithmetic is done at full width internally and truncated to AW at the output. Overflow of AW is a configuration error and is not detected.
- start is ignored in RUN and FIN.
- Reset values: all indices 0, valid=0, busy=0, done=0, acc_first=0, acc_last=0, pad=0, all addresses 0, state IDLE.
- Reset asserted during RUN aborts the pass immediately; done is not pulsed.

## Timing
- Start latency: start sampled in IDLE at edge t gives busy=1, valid=1 and the first tuple after edge t.
- Throughput: one tuple per cycle while ready=1.
- Total tuples per pass: N = OUT_CH*OUT_H*OUT_W*K*K*IN_CH.
- With ready held at 1: the last tuple is accepted at edge t+N, done is high for the cycle after edge t+N, and IDLE is re-entered at edge t+N+1. A new start is accepted from that point.
- Stall: while valid=1 and ready=0, every output holds its value unchanged. valid never drops mid-pass.
- busy falls in the same cycle that done rises.

## Test plan
- Configuration IM 4x4, K=3, PAD=1, STRIDE=1, IN_CH=2, OUT_CH=2, ready=1, start pulse.
  - Expect N=576 tuples, then one done pulse.
  - First tuple: in_row=-1, in_col=-1, pad=1, in_addr=0, w_addr=0, acc_first=1.
  - acc_last is seen 32 times.
- Same configuration, tuple oy=1, ox=1, ky=0, kx=0, ic=1: expect in_row=0, in_col=0, pad=0, in_addr=1, out_addr=10.
- Configuration IM 5x5, K=3, PAD=0, STRIDE=2, IN_CH=1, OUT_CH=1.
  - Expect OUT 2x2 and 36 tuples.
  - Tuple ox=1, kx=2 gives in_col=4; pad is never asserted.
- Random ready with about 50% duty:
  - Outputs are stable across every stall.
  - The accepted tuple sequence is identical to the ready=1 run.
  - done follows the final acceptance by exactly one cycle.
- Assert start again at the mid-pass cycle 100: no effect; the tuple count is still N.
- Drive reset=0 at mid-pass cycle 50: the next cycle shows valid=0, busy=0, all indices 0, no done pulse. A fresh start then runs a complete pass from the first tuple.
